ras_circ_ckpt: RTL and testbench

//  Circular return-address stack (RAS) for the frontend branch predictor.
//  - Sized from the core config: RASDepth, VLEN.
//  - Calls push the link address; returns pop and present the predicted target.
//  - One checkpoint lets the frontend roll back the stack pointer on a mispredict.
//  - Sits beside the BTB/BHT in the frontend and feeds the next-PC select.

---
 rtl/ras_circ_ckpt_pkg.sv | 16 +
 rtl/ras_circ_ckpt.sv | 101 ++++++++++
 tb/tb_ras_circ_ckpt.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ras_circ_ckpt_pkg.sv
// Shared types and sizing helpers for the circular return-address stack.
package ras_circ_ckpt_pkg;

  localparam int unsigned RAS_VLEN = 32;

  typedef struct packed {
    logic                valid;
    logic [RAS_VLEN-1:0] ra;
  } ras_t;

  // Pointer width for a stack of the given depth; never narrower than one bit.
  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ras_circ_ckpt.sv
// Circular return-address stack with a single tos/count checkpoint.
// Calls push the link address, returns pop it; the checkpoint rolls the
// pointer back after a mispredict. Entry contents are never restored, so a
// restored top may be stale or invalid, which the predictor tolerates.
module ras_circ_ckpt
  import ras_circ_ckpt_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = RAS_VLEN
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_bp_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [VLEN-1:0]              data_i,
  input  logic                         ckpt_save_i,
  input  logic                         ckpt_rest_i,
  output ras_t                         data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = ras_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] TOP_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Explicit wrap so non-power-of-two depths stay inside 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == TOP_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? TOP_PTR : p - 1'b1;
  endfunction

  logic [DEPTH-1:0] valid_mem;
  logic [VLEN-1:0]  ra_mem [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] ckpt_tos;
  logic [CNT_W-1:0] ckpt_count;
  logic [PTR_W-1:0] next_ptr;
  logic             stack_op;

  assign next_ptr = ptr_inc(tos);
  // Push/pop only take effect when nothing of higher priority happens.
  assign stack_op = !flush_bp_i && !ckpt_rest_i;

  assign data_o.valid = valid_mem[tos] && (count != '0);
  assign data_o.ra    = ra_mem[tos];
  assign count_o      = count;

  // Control state: valid bits, pointer, occupancy and checkpoint.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_mem  <= '0;
      tos        <= TOP_PTR;
      count      <= '0;
      ckpt_tos   <= TOP_PTR;
      ckpt_count <= '0;
    end else begin
      // Save samples the pre-update state; a flush in the same cycle wins.
      if (flush_bp_i) begin
        ckpt_tos   <= tos;
        ckpt_count <= '0;
      end else if (ckpt_save_i) begin
        ckpt_tos   <= tos;
        ckpt_count <= count;
      end

      if (flush_bp_i) begin
        valid_mem <= '0;
        count     <= '0;
      end else if (ckpt_rest_i) begin
        tos   <= ckpt_tos;
        count <= ckpt_count;
      end else if (push_i && pop_i) begin
        valid_mem[tos] <= 1'b1;
        if (count == '0) count <= CNT_W'(1);
      end else if (push_i) begin
        tos                 <= next_ptr;
        valid_mem[next_ptr] <= 1'b1;
        count               <= (count == FULL_CNT) ? FULL_CNT : count + 1'b1;
      end else if (pop_i && (count != '0)) begin
        valid_mem[tos] <= 1'b0;
        tos            <= ptr_dec(tos);
        count          <= count - 1'b1;
      end
    end
  end

  // Return-address storage; not reset, only written by an accepted push.
  always_ff @(posedge clk_i) begin
    if (!rst_i && stack_op && push_i) begin
      ra_mem[pop_i ? tos : next_ptr] <= data_i;
    end
  end

endmodule

// File: tb/tb_ras_circ_ckpt.sv
// Bench for ras_circ_ckpt: directed scenarios followed by random traffic
// compared against an array/modulo reference model of the stack.
module tb_ras_circ_ckpt;
  import ras_circ_ckpt_pkg::*;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst, flush, push, pop, save, rest;
  logic [31:0] din;
  ras_t        dout;
  logic [1:0]  cnt;

  int errors = 0;
  int checks = 0;

  bit          m_valid [D];
  logic [31:0] m_ra    [D];
  int          m_tos, m_cnt, m_ck_tos, m_ck_cnt;
  int          cov_full = 0;
  int          cov_wrap = 0;

  always #5 clk = ~clk;

  ras_circ_ckpt #(.DEPTH(D), .VLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_bp_i (flush),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (din),
    .ckpt_save_i(save),
    .ckpt_rest_i(rest),
    .data_o     (dout),
    .count_o    (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, f, pu, po, sv, rs, input logic [31:0] d);
    int pre_tos, pre_cnt;
    if (r) begin
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      m_tos = D - 1; m_cnt = 0; m_ck_tos = D - 1; m_ck_cnt = 0;
      return;
    end
    pre_tos = m_tos;
    pre_cnt = m_cnt;
    if (f) begin
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      m_cnt = 0;
    end else if (rs) begin
      m_tos = m_ck_tos;
      m_cnt = m_ck_cnt;
    end else if (pu && po) begin
      m_ra[m_tos] = d;
      m_valid[m_tos] = 1'b1;
      if (m_cnt == 0) m_cnt = 1;
    end else if (pu) begin
      if (m_tos == D - 1) cov_wrap++;
      m_tos = (m_tos + 1) % D;
      m_ra[m_tos] = d;
      m_valid[m_tos] = 1'b1;
      m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
      if (m_cnt == D) cov_full++;
    end else if (po && m_cnt > 0) begin
      m_valid[m_tos] = 1'b0;
      m_tos = (m_tos + D - 1) % D;
      m_cnt = m_cnt - 1;
    end
    if (f) begin
      m_ck_tos = pre_tos; m_ck_cnt = 0;
    end else if (sv) begin
      m_ck_tos = pre_tos; m_ck_cnt = pre_cnt;
    end
  endtask

  task automatic cyc(input bit r, f, pu, po, sv, rs, input logic [31:0] d);
    rst = r; flush = f; push = pu; pop = po; save = sv; rest = rs; din = d;
    model_step(r, f, pu, po, sv, rs, d);
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; save = 1'b0; rest = 1'b0; din = '0;
  endtask

  task automatic check_model(input string tag);
    bit ev;
    ev = m_valid[m_tos] && (m_cnt != 0);
    check({tag, ".valid"}, 64'(dout.valid), 64'(ev));
    check({tag, ".count"}, 64'(cnt), 64'(m_cnt));
    if (ev) check({tag, ".ra"}, 64'(dout.ra), 64'(m_ra[m_tos]));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; save = 1'b0; rest = 1'b0; din = '0;
    @(posedge clk);
    #1;

    // Reset, then pop on an empty stack
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst.valid", 64'(dout.valid), 64'd0);
    check("rst.count", 64'(cnt), 64'd0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("pop_empty.valid", 64'(dout.valid), 64'd0);
    check("pop_empty.count", 64'(cnt), 64'd0);

    // Basic push/pop
    cyc(0, 0, 1, 0, 0, 0, 32'h100);
    cyc(0, 0, 1, 0, 0, 0, 32'h200);
    check("t2.top", 64'(dout.ra), 64'h200);
    check("t2.count", 64'(cnt), 64'd2);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t2.pop1.top", 64'(dout.ra), 64'h100);
    check("t2.pop1.valid", 64'(dout.valid), 64'd1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t2.pop2.valid", 64'(dout.valid), 64'd0);
    check("t2.pop2.count", 64'(cnt), 64'd0);

    // Overflow wraps and loses the oldest entry
    cyc(0, 0, 1, 0, 0, 0, 32'h100);
    cyc(0, 0, 1, 0, 0, 0, 32'h200);
    cyc(0, 0, 1, 0, 0, 0, 32'h300);
    check("t3.count", 64'(cnt), 64'd2);
    check("t3.top", 64'(dout.ra), 64'h300);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t3.pop1.top", 64'(dout.ra), 64'h200);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t3.pop2.valid", 64'(dout.valid), 64'd0);
    check("t3.pop2.count", 64'(cnt), 64'd0);

    // Simultaneous push+pop replaces the top
    cyc(0, 0, 1, 0, 0, 0, 32'h100);
    cyc(0, 0, 1, 1, 0, 0, 32'h400);
    check("t4.top", 64'(dout.ra), 64'h400);
    check("t4.count", 64'(cnt), 64'd1);
    check("t4.valid", 64'(dout.valid), 64'd1);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // Checkpoint restore brings back pointer/count but not the cleared valid bit
    cyc(0, 0, 1, 0, 0, 0, 32'h100);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h200);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("t5.count", 64'(cnt), 64'd1);
    check("t5.stale_ra", 64'(dout.ra), 64'h100);
    check("t5.stale_valid", 64'(dout.valid), 64'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("t5.flush.valid", 64'(dout.valid), 64'd0);
    check("t5.flush.count", 64'(cnt), 64'd0);

    // Reset wins over a same-cycle push
    cyc(0, 0, 1, 0, 0, 0, 32'h111);
    cyc(1, 0, 1, 0, 0, 0, 32'h500);
    check("t6.count", 64'(cnt), 64'd0);
    check("t6.valid", 64'(dout.valid), 64'd0);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      bit pu, po, sv, rs, f, r;
      pu = ($urandom_range(0, 99) < 45);
      po = ($urandom_range(0, 99) < 40);
      sv = ($urandom_range(0, 99) < 12);
      rs = ($urandom_range(0, 99) < 10);
      f  = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 199) < 1);
      cyc(r, f, pu, po, sv, rs, $urandom);
      check_model("rnd");
    end

    check("cov_full", 64'(cov_full > 0), 64'd1);
    check("cov_wrap", 64'(cov_wrap > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
